uart_tx: RTL
============

# uart_tx

Serial transmitter that sits directly downstream of the synchronous `fifo`. It pops one byte at a time through the FIFO read port and shifts the byte out on `tx_o` as an 8N1/8N2 UART frame: start bit, data bits LSB first, then stop bit(s). Software writes into the FIFO and this block drains it at line rate. Together they form the UART transmit path of the SoC peripheral bus.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per frame; must equal the FIFO's `DATA_WIDTH`.
- `CLKS_PER_BIT`, 868: clock cycles per bit period, ≥ 2 (100 MHz / 115200).
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk_i` in 1: system clock; every register samples on its rising edge.
- `reset_n_i` in 1: synchronous, active-low reset.
- `fifo_empty_i` in 1: FIFO `fifo_empty_o`.
- `fifo_read_enable_o` out 1: drives the FIFO `read_enable_i`.
- `fifo_read_data_i` in `DATA_WIDTH`: FIFO `read_data_o`.
- `fifo_read_valid_i` in 1: FIFO `read_valid_o`.
- `tx_o` out 1: serial line; idle level is high.
- `busy_o` out 1: high while a frame is being fetched or sent.
- `frame_done_o` out 1: one-cycle pulse after the last stop-bit cycle.

## Operation
- State machine states: IDLE, FETCH, START, DATA, STOP.
- **IDLE:**
  - `tx_o`=1.
  - If `fifo_empty_i`=0, assert `fifo_read_enable_o` for exactly one cycle and go to FETCH.
  - `fifo_read_enable_o` is never asserted in any other state.
- **FETCH:**
  - If `fifo_read_valid_i`=1, latch `fifo_read_data_i` into the shift register, clear the baud counter and go to START.
  - Otherwise (spurious empty-flag race), return to IDLE. Nothing is transmitted and no byte is lost.
- **START:** `tx_o`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA:**
  - `tx_o`=shift register bit 0 for `CLKS_PER_BIT` cycles, then shift right and increment the bit index.
  - After bit `DATA_WIDTH-1`, go to STOP.
- **STOP:**
  - `tx_o`=1 for `STOP_BITS*CLKS_PER_BIT` cycles.
  - Then pulse `frame_done_o` and go to IDLE.
- **Baud counter:**
  - Width `$clog2(STOP_BITS*CLKS_PER_BIT)`.
  - Counts 0..limit-1 and reloads to 0 on every state change.
  - No overflow or wrap is possible within a state.
- **Bit index:** width `$clog2(DATA_WIDTH)`; it compares equal to `DATA_WIDTH-1` exactly once per frame.
- **Back-to-back frames:** IDLE→FETCH→START inserts 2 extra idle-high cycles between frames. This is legal extended stop time. No prefetch.
- **Reset:**
  - Reset at any point, including mid-frame, synchronously forces IDLE, `tx_o`=1, `busy_o`=0, `fifo_read_enable_o`=0, `frame_done_o`=0, and counters and shift register to 0.
  - A byte already popped is dropped. The FIFO contents are not touched.

## Timing
- Reset values: `tx_o`=1, `busy_o`=0, `fifo_read_enable_o`=0, `frame_done_o`=0.
- **Outputs:**
  - `tx_o`, `busy_o` and `frame_done_o` are registered.
  - `fifo_read_enable_o` is combinational from state and `fifo_empty_i`. It is safe because the FIFO registers its flags.
- **Fetch timing:**
  - Cycle N: IDLE, `fifo_empty_i`=0, `fifo_read_enable_o`=1.
  - N+1: FETCH; `fifo_read_valid_i` is expected here, matching the FIFO's 1-cycle read latency.
  - N+2: first START cycle; `tx_o`=0 is visible from the N+2 edge.
- **Frame length:** `(1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT` cycles of `tx_o` activity.
- **`busy_o`:**
  - Rises in the cycle after `fifo_read_enable_o`.
  - Falls in the same cycle as `frame_done_o`.
  - Per frame: `busy_o` high for `frame_length+1` cycles.

## Structure
- Package `common`: `uart_tx_state_t` enum (IDLE, FETCH, START, DATA, STOP) and the `byte_t` typedef, shared with the future `uart_rx`.
- Sub-module `uart_baud_gen`: parametrised baud counter with `clear_i`, a `limit_i` select (one bit period / stop period) and a `tick_o` on the terminal count. Reused by `uart_rx`.
- Top-level integration instantiates `fifo` plus `uart_tx` with the ports wired by name.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Reset idle:** hold `reset_n_i`=0 for 3 cycles, then release with the FIFO empty → `tx_o`=1, `busy_o`=0, `fifo_read_enable_o`=0 for 50 cycles.
- **Single byte 0xA5, `STOP_BITS`=1:** after the read, `tx_o` emits 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles) → `frame_done_o` pulses once and exactly one read is issued.
- **Back-to-back 0x00 then 0xFF:**
  - Frames are separated by exactly 2 extra high cycles.
  - Second frame: start 0, eight 1s, stop 1.
  - Two reads in total; the FIFO reports empty at the end.
- **`STOP_BITS`=2, byte 0x3C:** stop period is 8 cycles high → `busy_o` is high for 45 cycles in total.
- **Reset mid-frame:** assert `reset_n_i`=0 during DATA bit 3 of 0x55 → the next cycle shows `tx_o`=1, `busy_o`=0. After release, the next queued byte 0x12 transmits intact.
- **Spurious FETCH:** force `fifo_read_valid_i`=0 in the FETCH cycle → return to IDLE, `tx_o` stays 1, no `frame_done_o`.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART types: transmitter state encoding and the byte payload type.
package uart_tx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Baud counter: counts 0..limit-1, ticks on the terminal count, cleared on demand.
module uart_tx_baud_gen #(
  parameter int unsigned BIT_CLKS  = 868,
  parameter int unsigned STOP_CLKS = 868
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic limit_i,
  output logic tick_o
);

  localparam int unsigned CW = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

  logic [CW-1:0] count;
  logic [CW-1:0] last;

  // Terminal count select: one bit period or the whole stop period.
  always_comb begin
    last = limit_i ? CW'(STOP_CLKS - 1) : CW'(BIT_CLKS - 1);
  end

  assign tick_o = (count == last);

  // Counter register; reloads on clear or terminal count.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count <= '0;
    end else if (clear_i || tick_o) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a 1-cycle-latency FIFO into 8N1/8N2 frames.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_read_enable_o,
  input  logic [DATA_WIDTH-1:0] fifo_read_data_i,
  input  logic                  fifo_read_valid_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_tx_state_t        state, state_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  tx_n, busy_n, done_n;
  logic                  read_en;
  logic                  tick, clear, stop_sel;

  uart_tx_baud_gen #(
    .BIT_CLKS  (CLKS_PER_BIT),
    .STOP_CLKS (STOP_BITS * CLKS_PER_BIT)
  ) u_baud (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear),
    .limit_i   (stop_sel),
    .tick_o    (tick)
  );

  // Next state and next registered outputs; tx_n is the line level for the next cycle.
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    tx_n    = 1'b1;
    busy_n  = busy_o;
    done_n  = 1'b0;
    read_en = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        // reset_n_i gating keeps the FIFO untouched while reset is held.
        if (!fifo_empty_i && reset_n_i) begin
          read_en = 1'b1;
          busy_n  = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (fifo_read_valid_i) begin
          shift_n = fifo_read_data_i;
          idx_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = START;
        end else begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (tick) begin
          idx_n   = '0;
          tx_n    = shift[0];
          state_n = DATA;
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (tick) begin
          if (idx == IW'(DATA_WIDTH - 1)) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = shift >> 1;
            idx_n   = idx + IW'(1);
            tx_n    = shift_n[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    clear    = (state_n != state) || (state == IDLE);
    stop_sel = (state == STOP);
  end

  assign fifo_read_enable_o = read_en;

  // State, datapath and registered output flops.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      shift        <= '0;
      idx          <= '0;
      tx_o         <= 1'b1;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      shift        <= shift_n;
      idx          <= idx_n;
      tx_o         <= tx_n;
      busy_o       <= busy_n;
      frame_done_o <= done_n;
    end
  end

endmodule
